// File: rtl/rotary_button_interpret.sv
// Rotary encoder and push-button interpreter.
// Three asynchronous, bouncy inputs (quadrature A/B and the push-button) are
// synchronized, debounced, and decoded into one-clock pulses:
//   right - one pulse per clockwise detent
//   left  - one pulse per counter-clockwise detent
//   down  - one pulse per button press
// Rotation is decoded only on the rising edge of debounced A. The direction
// comes from the debounced B level held just before A was accepted.
module rotary_button_interpret #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rotA,
  input  logic rotB,
  input  logic rotCenter,
  output logic right,
  output logic left,
  output logic down
);

  // Channel indices into the packed per-input vectors.
  localparam int unsigned NumCh = 3;
  localparam int unsigned ChA   = 0;
  localparam int unsigned ChB   = 1;
  localparam int unsigned ChC   = 2;

  // The counter only needs to reach DEBOUNCE_CYCLES-1. On the clock after
  // that it accepts the new level and clears, so it can never wrap.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync_meta;
  logic [NumCh-1:0] sync_out;
  logic [NumCh-1:0] deb;
  logic [NumCh-1:0] deb_prev;
  logic             a_rise;
  logic             c_rise;

  assign raw = {rotCenter, rotB, rotA};

  // Two-flop synchronizer on every raw input, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // One independent debouncer per synchronized input.
  for (genvar i = 0; i < NumCh; i++) begin : g_deb
    logic [CntW-1:0] cnt;
    logic            level;

    // Count consecutive mismatches. Accept the new level on the
    // DEBOUNCE_CYCLES-th mismatch. A matching clock discards a partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_out[i] == level) begin
        cnt <= '0;
      end else if (cnt == CntLast) begin
        level <= sync_out[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = level;
  end

  // Delayed copy of the debounced levels. Used for edge detection and as the
  // pre-update B level.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_prev <= '0;
    end else begin
      deb_prev <= deb;
    end
  end

  assign a_rise = deb[ChA] & ~deb_prev[ChA];
  assign c_rise = deb[ChC] & ~deb_prev[ChC];

  // Registered single-clock pulses. right and left are exclusive because both
  // are gated by the same A rising edge and by opposite B levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      right <= 1'b0;
      left  <= 1'b0;
      down  <= 1'b0;
    end else begin
      right <= a_rise & ~deb_prev[ChB];
      left  <= a_rise &  deb_prev[ChB];
      down  <= c_rise;
    end
  end

endmodule

// File: tb/tb_rotary_button_interpret.sv
// Directed bench for rotary_button_interpret. Each stimulus step that should
// produce a pulse pushes the expected {right,left,down} vector and the
// expected cycle onto a scoreboard. The output vector is compared against the
// scoreboard every cycle in which either side is non-zero.
module tb_rotary_button_interpret;

  localparam int N   = 16;
  localparam int Lat = N + 3;

  typedef struct {
    logic [2:0] vec;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rotA = 1'b0;
  logic rotB = 1'b0;
  logic rotCenter = 1'b0;
  logic right;
  logic left;
  logic down;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rotary_button_interpret #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rotA     (rotA),
    .rotB     (rotB),
    .rotCenter(rotCenter),
    .right    (right),
    .left     (left),
    .down     (down)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expect a pulse pattern Lat clocks after the next sampling edge.
  task automatic expect_pulse(input logic [2:0] vec);
    exp_t e;
    e.vec = vec;
    e.cyc = cyc + Lat;
    sb.push_back(e);
  endtask

  // Advance one clock and compare the outputs on the falling edge.
  task automatic tick();
    logic [2:0] obs;
    logic [2:0] expv;
    @(negedge clk);
    obs  = {right, left, down};
    expv = 3'b000;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      if (sb[0].cyc == cyc) expv = expv | sb[0].vec;
      void'(sb.pop_front());
    end
    if (obs !== 3'b000 || expv !== 3'b000) begin
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL pulse cyc=%0d {right,left,down} observed=%b expected=%b", cyc, obs, expv);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold reset for n clocks and require all outputs low throughout.
  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      assert ({right, left, down} === 3'b000) else begin
        errors++;
        $error("FAIL reset_outputs observed=%b expected=000", {right, left, down});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    reset_cycles(4);
    idle(5);

    // Clockwise detent: A, B, A-fall, B-fall, 75 clocks apart.
    rotA = 1'b1;
    expect_pulse(3'b100);
    idle(75);
    rotB = 1'b1;
    idle(75);
    rotA = 1'b0;
    idle(75);
    rotB = 1'b0;
    idle(100);

    // Counter-clockwise detent: B leads A.
    rotB = 1'b1;
    idle(75);
    rotA = 1'b1;
    expect_pulse(3'b010);
    idle(75);
    rotB = 1'b0;
    idle(75);
    rotA = 1'b0;
    idle(100);

    // Button held for 25 us, then released.
    rotCenter = 1'b1;
    expect_pulse(3'b001);
    idle(625);
    rotCenter = 1'b0;
    idle(100);

    // Bouncy A: high 5, low 3, then stable high.
    rotA = 1'b1;
    idle(5);
    rotA = 1'b0;
    idle(3);
    rotA = 1'b1;
    expect_pulse(3'b100);
    idle(100);
    rotA = 1'b0;
    idle(100);

    // Button glitch just shorter than the filter.
    rotCenter = 1'b1;
    idle(N - 2);
    rotCenter = 1'b0;
    idle(100);

    // Reset partway through the A debounce aborts it. A is then refiltered
    // from release.
    rotA = 1'b1;
    idle(8);
    reset_cycles(3);
    expect_pulse(3'b100);
    idle(100);
    rotA = 1'b0;
    idle(60);

    // Rotation and button are independent and may pulse in the same clock.
    rotA = 1'b1;
    rotCenter = 1'b1;
    expect_pulse(3'b101);
    idle(100);
    rotA = 1'b0;
    rotCenter = 1'b0;
    idle(60);

    // Every expected pulse must have been consumed.
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
